// File: rtl/layer_wr_ctrl_if.sv
// Byte-stream input and per-layer RAM write bus for layer_wr_ctrl.
interface layer_wr_ctrl_if #(
    parameter int LAYERS = 8,
    parameter int WORDS  = 64,
    parameter int AW     = $clog2(WORDS)
);
    logic              frame_start_in;
    logic              byte_valid_in;
    logic [7:0]        byte_data_in;
    logic [LAYERS-1:0] wr_en_out;
    logic [AW-1:0]     wr_addr_out;
    logic [7:0]        wr_data_out;
    logic [3:0]        wr_byte_en_out;
    logic [LAYERS-1:0] wr_done_out;
    logic              frame_done_out;
    logic              busy_out;
    logic              err_out;

    // Host side: drives the byte stream, observes the write bus.
    modport master (
        output frame_start_in, byte_valid_in, byte_data_in,
        input  wr_en_out, wr_addr_out, wr_data_out, wr_byte_en_out,
        input  wr_done_out, frame_done_out, busy_out, err_out
    );

    // Controller side.
    modport slave (
        input  frame_start_in, byte_valid_in, byte_data_in,
        output wr_en_out, wr_addr_out, wr_data_out, wr_byte_en_out,
        output wr_done_out, frame_done_out, busy_out, err_out
    );
endinterface

// File: rtl/layer_wr_ctrl.sv
// Splits one serial byte stream per frame into sequential per-layer RAM writes.
module layer_wr_ctrl #(
    parameter int LAYERS = 8,
    parameter int WORDS  = 64,
    parameter int AW     = $clog2(WORDS)
) (
    input logic           clk_in,
    input logic           rst_in,
    layer_wr_ctrl_if.slave bus
);
    localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam int CW = AW + 2;
    localparam logic [CW-1:0] LAST_CNT   = CW'(4 * WORDS - 1);
    localparam logic [LW-1:0] LAST_LAYER = LW'(LAYERS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e            r_state, w_state_d;
    logic [LW-1:0]     r_layer, w_layer_d;
    logic [CW-1:0]     r_cnt, w_cnt_d;
    logic              r_err, w_err_d;
    logic [LAYERS-1:0] r_wr_en, w_wr_en_d;
    logic [AW-1:0]     r_addr, w_addr_d;
    logic [7:0]        r_data, w_data_d;
    logic [3:0]        r_be, w_be_d;
    logic [LAYERS-1:0] r_done_pipe, w_done_pipe_d;
    logic [LAYERS-1:0] r_wr_done;
    logic              r_frame_done;

    logic              w_accept;
    logic [LW-1:0]     w_acc_layer;
    logic [CW-1:0]     w_acc_cnt;

    // Next-state: frame_start wins first, then the (possibly coincident) byte is written.
    always_comb begin
        w_state_d     = r_state;
        w_layer_d     = r_layer;
        w_cnt_d       = r_cnt;
        w_err_d       = r_err;
        w_wr_en_d     = '0;
        w_addr_d      = r_addr;
        w_data_d      = r_data;
        w_be_d        = '0;
        w_done_pipe_d = '0;
        w_accept      = 1'b0;
        w_acc_layer   = r_layer;
        w_acc_cnt     = r_cnt;

        if (bus.frame_start_in) begin
            w_state_d   = StLoad;
            w_layer_d   = '0;
            w_cnt_d     = '0;
            w_err_d     = (r_state != StIdle);
            w_acc_layer = '0;
            w_acc_cnt   = '0;
            w_accept    = bus.byte_valid_in;
        end else begin
            if (r_state == StLoad) begin
                w_accept = bus.byte_valid_in;
            end else if (bus.byte_valid_in) begin
                w_err_d = 1'b1;
            end
            if (r_state == StDone) begin
                w_state_d = StIdle;
            end
        end

        if (w_accept) begin
            for (int i = 0; i < LAYERS; i++) begin
                w_wr_en_d[i] = (w_acc_layer == LW'(i));
            end
            w_addr_d = w_acc_cnt[CW-1:2];
            w_data_d = bus.byte_data_in;
            w_be_d   = 4'b1000 >> w_acc_cnt[1:0];
            if (w_acc_cnt == LAST_CNT) begin
                w_cnt_d                    = '0;
                w_done_pipe_d[w_acc_layer] = 1'b1;
                if (w_acc_layer == LAST_LAYER) begin
                    w_state_d = StDone;
                end else begin
                    w_layer_d = w_acc_layer + LW'(1);
                end
            end else begin
                w_cnt_d = w_acc_cnt + CW'(1);
            end
        end
    end

    // State, counters and registered write bus.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= StIdle;
            r_layer      <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_wr_en      <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_be         <= '0;
            r_done_pipe  <= '0;
            r_wr_done    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_layer      <= w_layer_d;
            r_cnt        <= w_cnt_d;
            r_err        <= w_err_d;
            r_wr_en      <= w_wr_en_d;
            r_addr       <= w_addr_d;
            r_data       <= w_data_d;
            r_be         <= w_be_d;
            // wr_done trails the final write strobe by one cycle; frame_done trails wr_done.
            r_done_pipe  <= w_done_pipe_d;
            r_wr_done    <= r_done_pipe;
            r_frame_done <= r_wr_done[LAYERS-1];
        end
    end

    assign bus.wr_en_out      = r_wr_en;
    assign bus.wr_addr_out    = r_addr;
    assign bus.wr_data_out    = r_data;
    assign bus.wr_byte_en_out = r_be;
    assign bus.wr_done_out    = r_wr_done;
    assign bus.frame_done_out = r_frame_done;
    assign bus.busy_out       = (r_state == StLoad);
    assign bus.err_out        = r_err;
endmodule
